decoder2_rr_arbiter: RTL and testbench
======================================

Name: decoder2_rr_arbiter

Overview:
- Four-requester round-robin arbiter that sequences the shared 2-to-4 decoder (enable D, selects A/B, one-hot Y).
- Grants one requester at a time and drives the decoder enable and selects so only the granted line is active.
- Enforces a one-cycle break-before-make gap and a programmable maximum hold time.
- Sits between requesting blocks and the decoder2 instance.

Parameters:
- MAX_HOLD, 8, maximum cycles a grant may be held; 0 disables the timeout; legal range 0..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; bit i = requester i; level-sensitive.
- done  input  1  release strobe from the current holder; ignored when no grant is active.
- en_d  output  1  decoder enable (drives D).
- sel_a  output  1  decoder select MSB (drives A).
- sel_b  output  1  decoder select LSB (drives B).
- grant  output  4  one-hot grant; mirrors the decoder output.
- busy  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; en_d=0, sel_a=0, sel_b=0, grant=0, busy=0, timeout=0.
  - hold_cnt=0; last=3, so requester 0 has the highest priority after reset.
  - Reset mid-grant drops the grant at that edge; no timeout pulse is generated.
- Index mapping: index = {sel_a, sel_b}. sel_a is the MSB. grant[index] is the active bit.
- All outputs are registered.
- Invariants, checked every cycle:
  - grant = en_d ? (1 << {sel_a,sel_b}) : 4'b0000.
  - busy = en_d.
  - At most one grant bit is set.
- State IDLE:
  - If req != 0, select the first set bit searching cyclically from (last+1) mod 4.
  - Next edge: state=GRANT, en_d=1, {sel_a,sel_b}=winner, grant=onehot(winner), busy=1, hold_cnt=0.
  - Latency is one cycle from the sampled request to a visible grant.
  - If req == 0, remain in IDLE with outputs at idle values.
  - sel_a/sel_b hold their last value while en_d=0.
- State GRANT: hold_cnt increments each cycle (saturating at 255). Release conditions, evaluated each cycle:
  - (a) done=1.
  - (b) req[index]=0 (requester withdrew).
  - (c) MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1.
- On release, at the next edge:
  - state=IDLE, en_d=0, grant=0, busy=0, last=index.
  - timeout=1 only if (c) is the sole cause; otherwise timeout=0.
  - The grant is visible for at most MAX_HOLD cycles.
- Simultaneous release causes: done or withdrawal takes precedence over timeout, so timeout=0.
- Break-before-make: after any release, at least one cycle with grant=0 occurs before the next grant. The next grant appears two cycles after the release is sampled, if requests are pending.
- timeout is a single-cycle pulse, cleared at the following edge.
- Fairness: with all four requesters continuously requesting and releasing via done, the grant order is 0,1,2,3,0,… and no requester waits more than 3 grant periods.
- done and req changes while in IDLE do not affect the arbitration pointer.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> grant=0, en_d=0, sel_a=sel_b=0, busy=0, timeout=0 throughout.
- After reset, req=4'b1111, done pulsed 2 cycles after each grant -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001; {sel_a,sel_b} equal to 00, 01, 10, 11 while en_d=1.
- req=4'b0100 held, done=0, MAX_HOLD=8 -> grant=0100 for exactly 8 cycles, then grant=0 with timeout=1 for one cycle, then grant=0100 again after the gap.
- Holder 1 active, done=1 and hold_cnt==MAX_HOLD-1 in the same cycle -> release with timeout=0; next grant, with req=4'b1010, goes to requester 3.
- Grant to requester 2, then req[2] drops to 0 with req=4'b0001 -> grant clears next cycle, then grant=0001 one cycle later, timeout=0.
- rst=1 while grant=1000 -> all outputs 0 at that edge. After release of rst with req=4'b1001 -> grant=0001 (pointer reset).

Source files
------------

// File: rtl/decoder2_rr_arbiter_if.sv
// Request/grant bundle between requesting blocks and the 2-to-4 decoder arbiter.
// The master side (requesters) drives req/done; the slave side (arbiter) drives the rest.
interface decoder2_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic       en_d;
  logic       sel_a;
  logic       sel_b;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  en_d, sel_a, sel_b, grant, busy, timeout
  );

  modport slave (
    input  req, done,
    output en_d, sel_a, sel_b, grant, busy, timeout
  );
endinterface

// File: rtl/decoder2_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 2-to-4 decoder, with a
// break-before-make idle cycle between grants and an optional hold-time limit.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no grant driven; picks the next requester after r_last
// ST_GRANT | decoder enabled for requester {sel_a,sel_b}; counts hold time
module decoder2_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  decoder2_rr_arbiter_if.slave   bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam bit         TO_EN     = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic       r_en_d;
  logic [1:0] r_sel;
  logic [3:0] r_grant;
  logic       r_timeout;
  logic [7:0] r_hold_cnt;
  logic [1:0] r_last;

  state_t     w_state_nx;
  logic       w_en_nx;
  logic [1:0] w_sel_nx;
  logic [3:0] w_grant_nx;
  logic       w_to_nx;
  logic [7:0] w_cnt_nx;
  logic [1:0] w_last_nx;

  logic       w_found;
  logic [1:0] w_winner;
  logic [1:0] w_idx;
  logic       w_rel_user;
  logic       w_rel_to;

  // Cyclic search starting one past the previous holder.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 2'd0;
    w_idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_rel_user = bus.done | ~bus.req[r_sel];
  assign w_rel_to   = TO_EN && (r_hold_cnt == HOLD_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_en_nx    = r_en_d;
    w_sel_nx   = r_sel;
    w_to_nx    = 1'b0;
    w_cnt_nx   = r_hold_cnt;
    w_last_nx  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nx = ST_GRANT;
          w_en_nx    = 1'b1;
          w_sel_nx   = w_winner;
          w_cnt_nx   = 8'd0;
        end
      end
      ST_GRANT: begin
        if (w_rel_user || w_rel_to) begin
          w_state_nx = ST_IDLE;
          w_en_nx    = 1'b0;
          w_last_nx  = r_sel;
          // A user release in the same cycle wins over the timeout.
          w_to_nx    = w_rel_to & ~w_rel_user;
        end else if (r_hold_cnt != 8'hFF) begin
          w_cnt_nx   = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_en_nx    = 1'b0;
      end
    endcase
    w_grant_nx = w_en_nx ? (4'b0001 << w_sel_nx) : 4'b0000;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_en_d     <= 1'b0;
      r_sel      <= 2'd0;
      r_grant    <= 4'b0000;
      r_timeout  <= 1'b0;
      r_hold_cnt <= 8'd0;
      r_last     <= 2'd3;
    end else begin
      r_state    <= w_state_nx;
      r_en_d     <= w_en_nx;
      r_sel      <= w_sel_nx;
      r_grant    <= w_grant_nx;
      r_timeout  <= w_to_nx;
      r_hold_cnt <= w_cnt_nx;
      r_last     <= w_last_nx;
    end
  end

  assign bus.en_d    = r_en_d;
  assign bus.sel_a   = r_sel[1];
  assign bus.sel_b   = r_sel[0];
  assign bus.grant   = r_grant;
  assign bus.busy    = r_en_d;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_decoder2_rr_arbiter.sv
// Directed bench for decoder2_rr_arbiter with MAX_HOLD=8; expected output
// vectors are written out by hand for each step.
module tb_decoder2_rr_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  decoder2_rr_arbiter_if bus ();

  decoder2_rr_arbiter #(.MAX_HOLD(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic en, input logic [1:0] sel,
                     input logic [3:0] gnt, input logic to);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {bus.en_d, bus.sel_a, bus.sel_b, bus.grant, bus.busy, bus.timeout};
    exp = {en, sel, gnt, en, to};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed={en,a,b,grant,busy,to}=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_no_req", 1'b0, 2'd0, 4'b0000, 1'b0);
    end

    // Fairness: all requesting, done pulsed in the second grant cycle
    bus.req = 4'b1111;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant", 1'b1, 2'(i), 4'b0001 << i, 1'b0);
      step();
      chk("rr_hold", 1'b1, 2'(i), 4'b0001 << i, 1'b0);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk("rr_gap", 1'b0, 2'(i), 4'b0000, 1'b0);
      step();
    end
    chk("rr_wrap", 1'b1, 2'd0, 4'b0001, 1'b0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    chk("rr_release", 1'b0, 2'd0, 4'b0000, 1'b0);
    step();

    // Timeout: requester 2 holds without done
    bus.req = 4'b0100;
    step();
    for (int k = 0; k < 8; k++) begin
      chk("to_hold", 1'b1, 2'd2, 4'b0100, 1'b0);
      step();
    end
    chk("to_pulse", 1'b0, 2'd2, 4'b0000, 1'b1);
    step();
    chk("to_regrant", 1'b1, 2'd2, 4'b0100, 1'b0);

    // Withdraw 2 and let requester 1 win (pointer 2 -> search 3,0,1)
    bus.req = 4'b0010;
    step();
    chk("wd2_gap", 1'b0, 2'd2, 4'b0000, 1'b0);
    step();
    chk("g1_grant", 1'b1, 2'd1, 4'b0010, 1'b0);
    for (int k = 0; k < 7; k++) step();
    chk("g1_cnt7", 1'b1, 2'd1, 4'b0010, 1'b0);
    // done coincides with the terminal hold count
    bus.done = 1'b1;
    bus.req  = 4'b1010;
    step();
    bus.done = 1'b0;
    chk("done_beats_to", 1'b0, 2'd1, 4'b0000, 1'b0);
    step();
    chk("next_is_3", 1'b1, 2'd3, 4'b1000, 1'b0);

    // Reset mid-grant
    rst = 1'b1;
    step();
    chk("rst_mid_grant", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst = 1'b0;
    bus.req = 4'b1001;
    step();
    chk("rst_ptr", 1'b1, 2'd0, 4'b0001, 1'b0);

    // Withdrawal path: move grant to 2, then drop req[2]
    bus.req = 4'b0100;
    step();
    chk("wd0_gap", 1'b0, 2'd0, 4'b0000, 1'b0);
    step();
    chk("g2_grant", 1'b1, 2'd2, 4'b0100, 1'b0);
    bus.req = 4'b0001;
    step();
    chk("wd2_clear", 1'b0, 2'd2, 4'b0000, 1'b0);
    step();
    chk("g0_after_wd", 1'b1, 2'd0, 4'b0001, 1'b0);

    // done/req activity in IDLE must not move the pointer (last=0)
    bus.done = 1'b1;
    step();
    chk("idle_rel", 1'b0, 2'd0, 4'b0000, 1'b0);
    bus.req = 4'b0000;
    step();
    chk("idle_done_ign", 1'b0, 2'd0, 4'b0000, 1'b0);
    step();
    bus.done = 1'b0;
    bus.req  = 4'b1111;
    step();
    chk("ptr_kept", 1'b1, 2'd1, 4'b0010, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
